// File: rtl/fu_issue_arbiter_pkg.sv
// Shared types and defaults for the execution-unit issue arbiter.
package fu_issue_arbiter_pkg;

   localparam int unsigned ROB_IDX_SIZE       = 5;
   localparam int unsigned LS_LATENCY_DEFAULT = 2;
   localparam int unsigned LS_CNT_W           = 3;

   typedef enum logic {
      FU_SEL_ALU = 1'b0,
      FU_SEL_LS  = 1'b1
   } fu_sel_t;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_LS_WAIT = 1'b1
   } arb_state_t;

   function automatic logic [LS_CNT_W-1:0] ls_cnt_init(input int unsigned latency);
      return LS_CNT_W'(latency - 1);
   endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Request/grant/writeback bundle between the two RSs, the arbiter and the ROB.
interface fu_issue_arbiter_if #(
   parameter int unsigned ROB_IDX_W = fu_issue_arbiter_pkg::ROB_IDX_SIZE
);

   logic                 in_alu_req;
   logic [ROB_IDX_W-1:0] in_alu_rob_idx;
   logic                 in_ls_req;
   logic [ROB_IDX_W-1:0] in_ls_rob_idx;
   logic                 in_flush;
   logic                 out_alu_grant;
   logic                 out_ls_grant;
   logic                 out_fu_alu_start;
   logic                 out_fu_ls_start;
   logic                 out_rob_done;
   logic [ROB_IDX_W-1:0] out_rob_dst_rob_index;
   logic                 out_rob_from_ls;
   logic                 out_busy;

   modport master (
      output in_alu_req, in_alu_rob_idx, in_ls_req, in_ls_rob_idx, in_flush,
      input  out_alu_grant, out_ls_grant, out_fu_alu_start, out_fu_ls_start,
             out_rob_done, out_rob_dst_rob_index, out_rob_from_ls, out_busy
   );

   modport slave (
      input  in_alu_req, in_alu_rob_idx, in_ls_req, in_ls_rob_idx, in_flush,
      output out_alu_grant, out_ls_grant, out_fu_alu_start, out_fu_ls_start,
             out_rob_done, out_rob_dst_rob_index, out_rob_from_ls, out_busy
   );

endinterface

// File: rtl/fu_issue_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: bit 0 = ALU, bit 1 = LS; one-hot grant.
module rr_arbiter2
   import fu_issue_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       en_i,
   input  fu_sel_t    last_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = '0;
      if (en_i) begin
         if (req_i == 2'b11) begin
            grant_o = (last_i == FU_SEL_LS) ? 2'b01 : 2'b10;
         end else begin
            grant_o = req_i;
         end
      end
   end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Issue arbiter for the shared ALU + dmem unit; single ROB writeback port with
// fixed per-class latency.
module fu_issue_arbiter
   import fu_issue_arbiter_pkg::*;
#(
   parameter int unsigned LS_LATENCY = LS_LATENCY_DEFAULT,
   parameter int unsigned ROB_IDX_W  = ROB_IDX_SIZE
) (
   input logic          in_clk,
   input logic          in_rst_n,
   fu_issue_arbiter_if.slave bus
);

   localparam logic [LS_CNT_W-1:0] LS_CNT_INIT = ls_cnt_init(LS_LATENCY);

   arb_state_t           state_q,   state_d;
   logic [LS_CNT_W-1:0]  ls_cnt_q,  ls_cnt_d;
   fu_sel_t              rr_last_q, rr_last_d;
   logic [ROB_IDX_W-1:0] ls_tag_q,  ls_tag_d;
   logic [ROB_IDX_W-1:0] rob_tag_q, rob_tag_d;
   logic                 done_q,    done_d;
   logic                 from_ls_q, from_ls_d;
   logic                 busy_q,    busy_d;
   logic [1:0]           grant;
   logic                 arb_en;

   // Grants are combinational, so reset must gate them directly.
   assign arb_en = in_rst_n && !bus.in_flush && (state_q == ARB_IDLE);

   rr_arbiter2 u_rr (
      .req_i   ({bus.in_ls_req, bus.in_alu_req}),
      .en_i    (arb_en),
      .last_i  (rr_last_q),
      .grant_o (grant)
   );

   assign bus.out_alu_grant         = grant[0];
   assign bus.out_ls_grant          = grant[1];
   assign bus.out_fu_alu_start      = grant[0];
   assign bus.out_fu_ls_start       = grant[1];
   assign bus.out_rob_done          = done_q;
   assign bus.out_rob_dst_rob_index = rob_tag_q;
   assign bus.out_rob_from_ls       = from_ls_q;
   assign bus.out_busy              = busy_q;

   always_comb begin
      state_d   = state_q;
      ls_cnt_d  = ls_cnt_q;
      rr_last_d = rr_last_q;
      ls_tag_d  = ls_tag_q;
      rob_tag_d = rob_tag_q;
      from_ls_d = from_ls_q;
      done_d    = 1'b0;
      if (bus.in_flush) begin
         state_d  = ARB_IDLE;
         ls_cnt_d = '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (grant[0]) begin
                  rr_last_d = FU_SEL_ALU;
                  done_d    = 1'b1;
                  rob_tag_d = bus.in_alu_rob_idx;
                  from_ls_d = 1'b0;
               end
               if (grant[1]) begin
                  rr_last_d = FU_SEL_LS;
                  state_d   = ARB_LS_WAIT;
                  ls_cnt_d  = LS_CNT_INIT;
                  ls_tag_d  = bus.in_ls_rob_idx;
               end
            end
            ARB_LS_WAIT: begin
               if (ls_cnt_q == '0) begin
                  done_d    = 1'b1;
                  rob_tag_d = ls_tag_q;
                  from_ls_d = 1'b1;
                  state_d   = ARB_IDLE;
               end else begin
                  ls_cnt_d = ls_cnt_q - LS_CNT_W'(1);
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
      busy_d = (state_d == ARB_LS_WAIT);
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q   <= ARB_IDLE;
         ls_cnt_q  <= '0;
         rr_last_q <= FU_SEL_LS;
         ls_tag_q  <= '0;
         rob_tag_q <= '0;
         done_q    <= 1'b0;
         from_ls_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ls_cnt_q  <= ls_cnt_d;
         rr_last_q <= rr_last_d;
         ls_tag_q  <= ls_tag_d;
         rob_tag_q <= rob_tag_d;
         done_q    <= done_d;
         from_ls_q <= from_ls_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Scoreboard bench for fu_issue_arbiter at LS_LATENCY 2 and 5.
module tb_fu_issue_arbiter;
   import fu_issue_arbiter_pkg::*;

   localparam int unsigned W = ROB_IDX_SIZE;

   typedef struct {
      logic [W-1:0] tag;
      logic         from_ls;
      int           due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   nchk  = 0;
   int   nerr  = 0;
   exp_t q2[$];
   exp_t q5[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   fu_issue_arbiter_if #(.ROB_IDX_W(W)) bus2 ();
   fu_issue_arbiter_if #(.ROB_IDX_W(W)) bus5 ();

   fu_issue_arbiter #(.LS_LATENCY(2), .ROB_IDX_W(W)) dut2 (
      .in_clk   (clk),
      .in_rst_n (rst_n),
      .bus      (bus2)
   );

   fu_issue_arbiter #(.LS_LATENCY(5), .ROB_IDX_W(W)) dut5 (
      .in_clk   (clk),
      .in_rst_n (rst_n),
      .bus      (bus5)
   );

   // completion monitors: every done pulse must match the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus2.out_rob_done === 1'b1) begin
            nchk++;
            if (q2.size() == 0) begin
               nerr++;
               $display("FAIL done_L2 cyc=%0d: got tag=%0d from_ls=%0b, required no completion",
                        cyc, bus2.out_rob_dst_rob_index, bus2.out_rob_from_ls);
            end else begin
               e = q2.pop_front();
               if (bus2.out_rob_dst_rob_index !== e.tag || bus2.out_rob_from_ls !== e.from_ls || cyc != e.due) begin
                  nerr++;
                  $display("FAIL done_L2: got tag=%0d from_ls=%0b cyc=%0d, required tag=%0d from_ls=%0b cyc=%0d",
                           bus2.out_rob_dst_rob_index, bus2.out_rob_from_ls, cyc, e.tag, e.from_ls, e.due);
               end
            end
         end
         while (q2.size() != 0 && q2[0].due < cyc) begin
            nchk++;
            nerr++;
            $display("FAIL missing_L2: got no completion by cyc=%0d, required tag=%0d at cyc=%0d", cyc, q2[0].tag, q2[0].due);
            void'(q2.pop_front());
         end
         if (bus5.out_rob_done === 1'b1) begin
            nchk++;
            if (q5.size() == 0) begin
               nerr++;
               $display("FAIL done_L5 cyc=%0d: got tag=%0d from_ls=%0b, required no completion",
                        cyc, bus5.out_rob_dst_rob_index, bus5.out_rob_from_ls);
            end else begin
               e = q5.pop_front();
               if (bus5.out_rob_dst_rob_index !== e.tag || bus5.out_rob_from_ls !== e.from_ls || cyc != e.due) begin
                  nerr++;
                  $display("FAIL done_L5: got tag=%0d from_ls=%0b cyc=%0d, required tag=%0d from_ls=%0b cyc=%0d",
                           bus5.out_rob_dst_rob_index, bus5.out_rob_from_ls, cyc, e.tag, e.from_ls, e.due);
               end
            end
         end
         while (q5.size() != 0 && q5[0].due < cyc) begin
            nchk++;
            nerr++;
            $display("FAIL missing_L5: got no completion by cyc=%0d, required tag=%0d at cyc=%0d", cyc, q5[0].tag, q5[0].due);
            void'(q5.pop_front());
         end
      end
   end

   task automatic drive2(input logic a, input int at, input logic l, input int lt, input logic f);
      bus2.in_alu_req     = a;
      bus2.in_alu_rob_idx = W'(at);
      bus2.in_ls_req      = l;
      bus2.in_ls_rob_idx  = W'(lt);
      bus2.in_flush       = f;
   endtask

   task automatic drive5(input logic a, input int at, input logic l, input int lt, input logic f);
      bus5.in_alu_req     = a;
      bus5.in_alu_rob_idx = W'(at);
      bus5.in_ls_req      = l;
      bus5.in_ls_rob_idx  = W'(lt);
      bus5.in_flush       = f;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive2(1, 1, 1, 2, 0);
      drive5(1, 1, 1, 2, 0);
      repeat (2) @(negedge clk);
      #1;
      nchk++;
      if ({bus2.out_alu_grant, bus2.out_ls_grant, bus5.out_alu_grant, bus5.out_ls_grant} !== 4'b0000) begin
         nerr++;
         $display("FAIL reset_grants: got L2 %0b%0b L5 %0b%0b, required 00 00",
                  bus2.out_alu_grant, bus2.out_ls_grant, bus5.out_alu_grant, bus5.out_ls_grant);
      end
      nchk++;
      if ({bus2.out_rob_done, bus2.out_rob_from_ls, bus2.out_busy} !== 3'b000 || bus2.out_rob_dst_rob_index !== '0) begin
         nerr++;
         $display("FAIL reset_outs_L2: got done=%0b from_ls=%0b busy=%0b tag=%0d, required all 0",
                  bus2.out_rob_done, bus2.out_rob_from_ls, bus2.out_busy, bus2.out_rob_dst_rob_index);
      end
      nchk++;
      if ({bus5.out_rob_done, bus5.out_rob_from_ls, bus5.out_busy} !== 3'b000 || bus5.out_rob_dst_rob_index !== '0) begin
         nerr++;
         $display("FAIL reset_outs_L5: got done=%0b from_ls=%0b busy=%0b tag=%0d, required all 0",
                  bus5.out_rob_done, bus5.out_rob_from_ls, bus5.out_busy, bus5.out_rob_dst_rob_index);
      end
      drive2(0, 0, 0, 0, 0);
      drive5(0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_alu_only();
      int tags[6] = '{5, 5, 5, 1, 2, 3};
      foreach (tags[i]) begin
         @(negedge clk);
         drive2(1, tags[i], 0, 0, 0);
         #1;
         nchk++;
         if ({bus2.out_alu_grant, bus2.out_ls_grant, bus2.out_fu_alu_start, bus2.out_fu_ls_start} !== 4'b1010) begin
            nerr++;
            $display("FAIL alu_grant[%0d]: got alu=%0b ls=%0b start=%0b%0b, required alu=1 ls=0 start=10", i,
                     bus2.out_alu_grant, bus2.out_ls_grant, bus2.out_fu_alu_start, bus2.out_fu_ls_start);
         end
         q2.push_back('{W'(tags[i]), 1'b0, cyc + 1});
      end
      @(negedge clk);
      drive2(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ls_only();
      logic exp_busy;
      @(negedge clk);
      drive2(0, 0, 1, 9, 0);
      #1;
      nchk++;
      if ({bus2.out_alu_grant, bus2.out_ls_grant, bus2.out_fu_ls_start} !== 3'b011) begin
         nerr++;
         $display("FAIL ls_grant: got alu=%0b ls=%0b start=%0b, required alu=0 ls=1 start=1",
                  bus2.out_alu_grant, bus2.out_ls_grant, bus2.out_fu_ls_start);
      end
      q2.push_back('{W'(9), 1'b1, cyc + 3});
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) drive2(0, 0, 0, 0, 0);
         #1;
         exp_busy = (k <= 2);
         nchk++;
         if (bus2.out_busy !== exp_busy) begin
            nerr++;
            $display("FAIL ls_busy[%0d]: got %0b, required %0b", k, bus2.out_busy, exp_busy);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         drive2(1, 3, 1, 7, 0);
         #1;
         case (k % 4)
            0:       exp_g = 2'b10;
            1:       exp_g = 2'b01;
            default: exp_g = 2'b00;
         endcase
         nchk++;
         if ({bus2.out_alu_grant, bus2.out_ls_grant} !== exp_g) begin
            nerr++;
            $display("FAIL contention[%0d]: got alu,ls=%0b%0b, required %0b", k,
                     bus2.out_alu_grant, bus2.out_ls_grant, exp_g);
         end
         if (exp_g == 2'b10) q2.push_back('{W'(3), 1'b0, cyc + 1});
         if (exp_g == 2'b01) q2.push_back('{W'(7), 1'b1, cyc + 3});
      end
      @(negedge clk);
      drive2(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_flush();
      logic       ta[8] = '{0, 1, 1, 1, 1, 1, 1, 1};
      logic       tl[8] = '{1, 0, 0, 1, 1, 0, 0, 0};
      logic       tf[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
      logic [1:0] tg[8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         drive2(ta[k], 6, tl[k], (k == 0) ? 4 : 8, tf[k]);
         #1;
         nchk++;
         if ({bus2.out_alu_grant, bus2.out_ls_grant} !== tg[k]) begin
            nerr++;
            $display("FAIL flush_grant[%0d]: got alu,ls=%0b%0b, required %0b", k,
                     bus2.out_alu_grant, bus2.out_ls_grant, tg[k]);
         end
         if (k == 2) begin
            nchk++;
            if (bus2.out_busy !== 1'b0) begin
               nerr++;
               $display("FAIL flush_busy: got %0b, required 0", bus2.out_busy);
            end
         end
         if (k == 2 || k == 7) q2.push_back('{W'(6), 1'b0, cyc + 1});
         if (k == 4) q2.push_back('{W'(8), 1'b1, cyc + 3});
      end
      @(negedge clk);
      drive2(0, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      drive2(0, 0, 1, 10, 0);
      #1;
      nchk++;
      if ({bus2.out_alu_grant, bus2.out_ls_grant} !== 2'b01) begin
         nerr++;
         $display("FAIL rstmid_grant: got alu,ls=%0b%0b, required 01", bus2.out_alu_grant, bus2.out_ls_grant);
      end
      @(negedge clk);
      drive2(0, 0, 0, 0, 0);
      #1;
      nchk++;
      if (bus2.out_busy !== 1'b1) begin
         nerr++;
         $display("FAIL rstmid_busy_before: got %0b, required 1", bus2.out_busy);
      end
      #1;
      rst_n = 1'b0;
      #1;
      nchk++;
      if ({bus2.out_busy, bus2.out_rob_done, bus2.out_rob_from_ls} !== 3'b000 || bus2.out_rob_dst_rob_index !== '0) begin
         nerr++;
         $display("FAIL rstmid_async: got busy=%0b done=%0b from_ls=%0b tag=%0d, required all 0",
                  bus2.out_busy, bus2.out_rob_done, bus2.out_rob_from_ls, bus2.out_rob_dst_rob_index);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive2(1, 1, 1, 2, 0);
      #1;
      nchk++;
      if ({bus2.out_alu_grant, bus2.out_ls_grant} !== 2'b10) begin
         nerr++;
         $display("FAIL rstmid_tie: got alu,ls=%0b%0b, required 10", bus2.out_alu_grant, bus2.out_ls_grant);
      end
      q2.push_back('{W'(1), 1'b0, cyc + 1});
      @(negedge clk);
      drive2(0, 0, 0, 0, 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_latency5();
      @(negedge clk);
      drive5(0, 0, 1, 12, 0);
      #1;
      nchk++;
      if ({bus5.out_alu_grant, bus5.out_ls_grant} !== 2'b01) begin
         nerr++;
         $display("FAIL l5_ls_grant: got alu,ls=%0b%0b, required 01", bus5.out_alu_grant, bus5.out_ls_grant);
      end
      q5.push_back('{W'(12), 1'b1, cyc + 6});
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         drive5(1, 2, 0, 0, 0);
         #1;
         nchk++;
         if ({bus5.out_alu_grant, bus5.out_ls_grant, bus5.out_busy} !== 3'b001) begin
            nerr++;
            $display("FAIL l5_wait[%0d]: got alu,ls,busy=%0b%0b%0b, required 001", k,
                     bus5.out_alu_grant, bus5.out_ls_grant, bus5.out_busy);
         end
      end
      @(negedge clk);
      #1;
      nchk++;
      if ({bus5.out_alu_grant, bus5.out_ls_grant, bus5.out_busy} !== 3'b100) begin
         nerr++;
         $display("FAIL l5_alu_after: got alu,ls,busy=%0b%0b%0b, required 100",
                  bus5.out_alu_grant, bus5.out_ls_grant, bus5.out_busy);
      end
      q5.push_back('{W'(2), 1'b0, cyc + 1});
      @(negedge clk);
      drive5(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no end of run by %0t, required completion", $time);
      $fatal(1);
   end

   initial begin
      drive2(0, 0, 0, 0, 0);
      drive5(0, 0, 0, 0, 0);
      test_reset();
      test_alu_only();
      test_ls_only();
      test_contention();
      test_flush();
      test_reset_mid_op();
      test_latency5();
      nchk++;
      if (q2.size() + q5.size() != 0) begin
         nerr++;
         $display("FAIL leftover: got %0d pending completions, required 0", q2.size() + q5.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
